// File: rtl/backtrack_ctrl.sv
// Decision sequencer for decider_stack: forwards decisions as pushes and runs chronological
// backtracking on a BCP conflict, flipping the most recent untried decision or declaring UNSAT.
module backtrack_ctrl #(
    parameter int unsigned N_VARS = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             decide_valid,
    input  logic [IDX_W-1:0] decide_var,
    input  logic             decide_val,
    output logic             decide_ready,
    input  logic             conflict,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [IDX_W-1:0] stk_idx_in,
    input  logic [IDX_W-1:0] stk_idx_out,
    input  logic             stk_empty,
    output logic             var_wr_en,
    output logic [IDX_W-1:0] var_wr_idx,
    output logic [1:0]       var_wr_val,
    output logic             resume,
    output logic             unsat,
    output logic             busy,
    output logic [IDX_W:0]   depth,
    output logic             overflow
);

    localparam logic [IDX_W:0] FullDepth = (IDX_W + 1)'(N_VARS);

    typedef enum logic [2:0] {StIdle, StPop, StEval, StFlip, StUnsat} state_e;

    state_e            state_q;
    logic [IDX_W:0]    depth_q;
    logic [IDX_W-1:0]  cur_var_q;
    logic [N_VARS-1:0] pol_q;
    logic [N_VARS-1:0] tried_q;
    logic              overflow_q;
    logic              full;

    assign full = (depth_q == FullDepth);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            depth_q    <= '0;
            cur_var_q  <= '0;
            pol_q      <= '0;
            tried_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A conflict wins over a same-cycle decision, which is dropped.
                    if (conflict) begin
                        state_q <= StPop;
                    end else if (decide_valid) begin
                        if (!full) begin
                            pol_q[decide_var]   <= decide_val;
                            tried_q[decide_var] <= 1'b0;
                            depth_q             <= depth_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                StPop: begin
                    if (stk_empty) begin
                        state_q <= StUnsat;
                    end else begin
                        cur_var_q <= stk_idx_out;
                        depth_q   <= depth_q - 1'b1;
                        state_q   <= StEval;
                    end
                end
                StEval: begin
                    if (tried_q[cur_var_q]) begin
                        tried_q[cur_var_q] <= 1'b0;
                        state_q            <= StPop;
                    end else begin
                        state_q <= StFlip;
                    end
                end
                StFlip: begin
                    pol_q[cur_var_q]   <= !pol_q[cur_var_q];
                    tried_q[cur_var_q] <= 1'b1;
                    depth_q            <= depth_q + 1'b1;
                    state_q            <= StIdle;
                end
                StUnsat: state_q <= StUnsat;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        decide_ready = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_idx_in   = '0;
        var_wr_en    = 1'b0;
        var_wr_idx   = '0;
        var_wr_val   = 2'b00;
        resume       = 1'b0;
        unsat        = 1'b0;
        busy         = 1'b0;
        depth        = '0;
        overflow     = 1'b0;
        // Outputs are held low while reset is asserted.
        if (!reset) begin
            busy     = (state_q != StIdle);
            depth    = depth_q;
            overflow = overflow_q;
            unique case (state_q)
                StIdle: begin
                    decide_ready = !conflict && !full;
                    if (decide_valid && decide_ready) begin
                        stk_push   = 1'b1;
                        stk_idx_in = decide_var;
                        var_wr_en  = 1'b1;
                        var_wr_idx = decide_var;
                        var_wr_val = {decide_val, !decide_val};
                    end
                end
                StPop: stk_pop = !stk_empty;
                StEval: begin
                    if (tried_q[cur_var_q]) begin
                        var_wr_en  = 1'b1;
                        var_wr_idx = cur_var_q;
                        var_wr_val = 2'b00;
                    end
                end
                StFlip: begin
                    var_wr_en  = 1'b1;
                    var_wr_idx = cur_var_q;
                    var_wr_val = pol_q[cur_var_q] ? 2'b01 : 2'b10;
                    stk_push   = 1'b1;
                    stk_idx_in = cur_var_q;
                    resume     = 1'b1;
                end
                StUnsat: unsat = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Bench for backtrack_ctrl: a trail-based search model predicts every output each cycle, and a
// queue stands in for decider_stack.
module tb_backtrack_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          decide_valid;
    logic [IW-1:0] decide_var;
    logic          decide_val;
    logic          decide_ready;
    logic          conflict;
    logic          stk_push;
    logic          stk_pop;
    logic [IW-1:0] stk_idx_in;
    logic [IW-1:0] stk_idx_out = '0;
    logic          stk_empty = 1'b1;
    logic          var_wr_en;
    logic [IW-1:0] var_wr_idx;
    logic [1:0]    var_wr_val;
    logic          resume;
    logic          unsat;
    logic          busy;
    logic [IW:0]   depth;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    backtrack_ctrl #(.N_VARS(N), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .decide_valid(decide_valid), .decide_var(decide_var), .decide_val(decide_val),
        .decide_ready(decide_ready), .conflict(conflict),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_idx_in(stk_idx_in),
        .stk_idx_out(stk_idx_out), .stk_empty(stk_empty),
        .var_wr_en(var_wr_en), .var_wr_idx(var_wr_idx), .var_wr_val(var_wr_val),
        .resume(resume), .unsat(unsat), .busy(busy), .depth(depth), .overflow(overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // decider_stack stand-in: strobes seen mid-cycle take effect at the next edge.
    logic [IW-1:0] stk_q[$];
    bit            pend_push, pend_pop;
    logic [IW-1:0] pend_idx;

    always @(negedge clock) begin
        pend_push = stk_push;
        pend_pop  = stk_pop;
        pend_idx  = stk_idx_in;
    end

    always @(posedge clock) begin
        if (reset) begin
            stk_q.delete();
        end else begin
            if (pend_pop && stk_q.size() > 0) void'(stk_q.pop_back());
            if (pend_push) stk_q.push_back(pend_idx);
        end
        stk_idx_out <= (stk_q.size() > 0) ? stk_q[$] : '0;
        stk_empty   <= (stk_q.size() == 0);
    end

    // Search model: trail of decisions plus a list of expected cycles for a running backtrack.
    typedef struct {int v; bit pol; bit tried;} ent_t;
    typedef struct {bit push; bit pop; bit wr; bit res; int pidx; int widx; int wval; int dep;} step_t;

    ent_t  trail[$];
    step_t plan[$];
    bit    m_unsat_pend = 0;
    bit    m_unsat = 0;
    bit    m_ovf = 0;

    task automatic build_plan();
        int    d;
        ent_t  top;
        step_t s;
        d = trail.size();
        while (1) begin
            if (trail.size() == 0) begin
                s = '{default: 0};
                plan.push_back(s);
                m_unsat_pend = 1;
                break;
            end
            top = trail.pop_back();
            s = '{default: 0}; s.pop = 1; s.dep = d;
            plan.push_back(s);
            d--;
            if (top.tried) begin
                s = '{default: 0}; s.wr = 1; s.widx = top.v; s.wval = 0; s.dep = d;
                plan.push_back(s);
            end else begin
                s = '{default: 0}; s.dep = d;
                plan.push_back(s);
                s = '{default: 0}; s.wr = 1; s.widx = top.v; s.wval = top.pol ? 1 : 2;
                s.push = 1; s.pidx = top.v; s.res = 1; s.dep = d;
                plan.push_back(s);
                trail.push_back('{top.v, !top.pol, 1'b1});
                break;
            end
        end
    endtask

    always @(negedge clock) begin : compare
        step_t e;
        bit    e_ready, e_busy, e_unsat, e_ovf;
        e = '{default: 0};
        e_ready = 0; e_busy = 0; e_unsat = 0; e_ovf = 0;
        if (!reset) begin
            e_ovf = m_ovf;
            if (plan.size() > 0) begin
                e = plan[0];
                e_busy = 1;
            end else if (m_unsat) begin
                e_unsat = 1;
                e_busy = 1;
            end else begin
                e.dep = trail.size();
                e_ready = !conflict && (trail.size() < N);
                if (e_ready && decide_valid) begin
                    e.push = 1; e.pidx = int'(decide_var);
                    e.wr = 1; e.widx = int'(decide_var); e.wval = decide_val ? 2 : 1;
                end
            end
        end
        chk("decide_ready", decide_ready, e_ready);
        chk("stk_push", stk_push, e.push);
        chk("stk_pop", stk_pop, e.pop);
        chk("var_wr_en", var_wr_en, e.wr);
        chk("resume", resume, e.res);
        chk("unsat", unsat, e_unsat);
        chk("busy", busy, e_busy);
        chk("depth", depth, e.dep);
        chk("overflow", overflow, e_ovf);
        if (e.push) chk("stk_idx_in", stk_idx_in, e.pidx);
        if (e.wr) begin
            chk("var_wr_idx", var_wr_idx, e.widx);
            chk("var_wr_val", var_wr_val, e.wval);
        end
        // Advance the model to the next cycle.
        if (reset) begin
            trail.delete(); plan.delete();
            m_unsat_pend = 0; m_unsat = 0; m_ovf = 0;
        end else if (plan.size() > 0) begin
            void'(plan.pop_front());
            if (plan.size() == 0 && m_unsat_pend) begin
                m_unsat = 1;
                m_unsat_pend = 0;
            end
        end else if (!m_unsat) begin
            if (conflict) build_plan();
            else if (decide_valid) begin
                if (trail.size() < N) trail.push_back('{int'(decide_var), decide_val, 1'b0});
                else m_ovf = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic decide(input int v, input bit val);
        decide_valid = 1'b1;
        decide_var   = IW'(v);
        decide_val   = val;
        tick();
        decide_valid = 1'b0;
    endtask

    task automatic pulse_conflict();
        conflict = 1'b1;
        tick();
        conflict = 1'b0;
    endtask

    // Called one cycle after the conflict cycle; returns at the negedge of the event cycle.
    task automatic wait_event(input string name, input bit want_unsat, input int exp_lat);
        int n;
        bit seen;
        n = 1;
        seen = 0;
        while (n <= 30) begin
            @(negedge clock);
            if (want_unsat ? unsat : resume) begin
                seen = 1;
                break;
            end
            tick();
            n++;
        end
        chk(name, seen ? n : -1, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; decide_valid = 1'b0; decide_var = '0; decide_val = 1'b0; conflict = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Decide v3=1, v7=0, conflict: v7 flips to true.
        decide(3, 1'b1);
        decide(7, 1'b0);
        pulse_conflict();
        wait_event("t1_resume_latency", 1'b0, 3);
        chk("t1_wr_idx", var_wr_idx, 7);
        chk("t1_wr_val", var_wr_val, 2);
        tick();
        @(negedge clock);
        chk("t1_depth", depth, 2);
        tick();

        // v7 exhausted and unassigned, v3 flips to false.
        pulse_conflict();
        wait_event("t2_resume_latency", 1'b0, 5);
        chk("t2_wr_idx", var_wr_idx, 3);
        chk("t2_wr_val", var_wr_val, 1);
        chk("t2_push_idx", stk_idx_in, 3);
        tick();
        @(negedge clock);
        chk("t2_depth", depth, 1);
        tick();

        // v3 exhausted, stack empties: UNSAT, decisions refused.
        pulse_conflict();
        wait_event("t3_unsat_latency", 1'b1, 4);
        chk("t3_busy", busy, 1);
        tick();
        decide_valid = 1'b1; decide_var = 3'd2; decide_val = 1'b1;
        @(negedge clock);
        chk("t3_ready", decide_ready, 0);
        chk("t3_push", stk_push, 0);
        tick();
        decide_valid = 1'b0;
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Conflict and decision in the same cycle: decision dropped.
        decide(1, 1'b1);
        conflict = 1'b1; decide_valid = 1'b1; decide_var = 3'd5; decide_val = 1'b1;
        @(negedge clock);
        chk("t4_ready", decide_ready, 0);
        chk("t4_push", stk_push, 0);
        tick();
        conflict = 1'b0; decide_valid = 1'b0;
        wait_event("t4_resume_latency", 1'b0, 3);
        chk("t4_wr_idx", var_wr_idx, 1);
        chk("t4_wr_val", var_wr_val, 1);
        tick();
        @(negedge clock);
        chk("t4_depth", depth, 1);
        tick();

        // Fill to N_VARS, then one more decision overflows.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) decide(i, i[0]);
        @(negedge clock);
        chk("t5_depth_full", depth, N);
        tick();
        decide_valid = 1'b1; decide_var = 3'd0; decide_val = 1'b1;
        @(negedge clock);
        chk("t5_ready", decide_ready, 0);
        chk("t5_push", stk_push, 0);
        tick();
        decide_valid = 1'b0;
        @(negedge clock);
        chk("t5_overflow", overflow, 1);
        tick();

        // Reset while evaluating the popped variable.
        pulse_conflict();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_depth", depth, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_resume", resume, 0);
        chk("t6_ready", decide_ready, 1);
        tick();
        decide(2, 1'b0);
        pulse_conflict();
        wait_event("t6_resume_latency", 1'b0, 3);
        chk("t6_wr_idx", var_wr_idx, 2);
        chk("t6_wr_val", var_wr_val, 2);
        tick();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
